// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic-light phase controller and its environment
// (shared down-counter, board buttons/switches, lamp drivers).
interface traffic_light_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             zero_i;
  logic             ped_req_i;
  logic             flash_i;
  logic             load_o;
  logic [WIDTH-1:0] data_o;
  logic [2:0]       main_o;
  logic [2:0]       side_o;
  logic             walk_o;
  logic             ped_pend_o;

  modport master (
    input  zero_i, ped_req_i, flash_i,
    output load_o, data_o, main_o, side_o, walk_o, ped_pend_o
  );

  modport slave (
    output zero_i, ped_req_i, flash_i,
    input  load_o, data_o, main_o, side_o, walk_o, ped_pend_o
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light phase controller with latched pedestrian request and
// night flash mode; drives the load/data side of an external down-counter.
module traffic_light_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned T_MAIN_G = 9,
  parameter int unsigned T_SIDE_G = 5,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_RED    = 1,
  parameter int unsigned T_FLASH  = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  traffic_light_ctrl_if.master bus
);

  localparam logic [2:0] StMainG = 3'd0;
  localparam logic [2:0] StMainY = 3'd1;
  localparam logic [2:0] StRed1  = 3'd2;
  localparam logic [2:0] StSideG = 3'd3;
  localparam logic [2:0] StSideY = 3'd4;
  localparam logic [2:0] StRed2  = 3'd5;
  localparam logic [2:0] StFlash = 3'd6;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  logic [2:0] state_q, state_d;
  logic       entry_q, entry_d;
  logic       blink_q, blink_d;
  logic       walk_q, walk_d;
  logic       pend_q, pend_d;
  logic       expire;

  // The counter value is stale during the load cycle, so its zero flag is ignored then.
  assign expire = ~entry_q & bus.zero_i;

  always_comb begin
    state_d = state_q;
    entry_d = expire;
    blink_d = blink_q;
    walk_d  = walk_q;
    pend_d  = pend_q | bus.ped_req_i;
    case (state_q)
      StMainG: if (expire) state_d = StMainY;
      StMainY: if (expire) state_d = StRed1;
      StRed1: begin
        if (expire) begin
          if (bus.flash_i) begin
            state_d = StFlash;
            blink_d = 1'b1;
          end else begin
            // A request arriving in this very cycle is served by this side green.
            state_d = StSideG;
            walk_d  = pend_q | bus.ped_req_i;
            pend_d  = 1'b0;
          end
        end
      end
      StSideG: begin
        if (expire) begin
          state_d = StSideY;
          walk_d  = 1'b0;
        end
      end
      StSideY: if (expire) state_d = StRed2;
      StRed2: begin
        if (expire) begin
          if (bus.flash_i) begin
            state_d = StFlash;
            blink_d = 1'b1;
          end else begin
            state_d = StMainG;
          end
        end
      end
      StFlash: begin
        if (expire) begin
          if (bus.flash_i) begin
            blink_d = ~blink_q;
          end else begin
            state_d = StRed2;
            blink_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StRed2;
        entry_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRed2;
      entry_q <= 1'b1;
      blink_q <= 1'b0;
      walk_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      blink_q <= blink_d;
      walk_q  <= walk_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    bus.main_o     = LampRed;
    bus.side_o     = LampRed;
    bus.data_o     = WIDTH'(T_RED);
    bus.load_o     = entry_q;
    bus.walk_o     = walk_q & (state_q == StSideG);
    bus.ped_pend_o = pend_q;
    case (state_q)
      StMainG: begin
        bus.main_o = LampGrn;
        bus.data_o = WIDTH'(T_MAIN_G);
      end
      StMainY: begin
        bus.main_o = LampYel;
        bus.data_o = WIDTH'(T_YEL);
      end
      StSideG: begin
        bus.side_o = LampGrn;
        bus.data_o = WIDTH'(T_SIDE_G);
      end
      StSideY: begin
        bus.side_o = LampYel;
        bus.data_o = WIDTH'(T_YEL);
      end
      StFlash: begin
        bus.main_o = {1'b0, blink_q, 1'b0};
        bus.side_o = {1'b0, blink_q, 1'b0};
        bus.data_o = WIDTH'(T_FLASH);
      end
      default: ;
    endcase
    // Hold a safe all-red, loading state for as long as reset is asserted.
    if (rst_i) begin
      bus.main_o     = LampRed;
      bus.side_o     = LampRed;
      bus.data_o     = WIDTH'(T_RED);
      bus.load_o     = 1'b1;
      bus.walk_o     = 1'b0;
      bus.ped_pend_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl driving a simple load/decrement down-counter;
// every phase is checked cycle by cycle against hand-computed lamps, load and dwell.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] cnt;
  int checks = 0;
  int errors = 0;

  traffic_light_ctrl_if #(.WIDTH(4)) bus ();

  traffic_light_ctrl #(
    .WIDTH(4), .T_MAIN_G(9), .T_SIDE_G(5), .T_YEL(2), .T_RED(1), .T_FLASH(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Down-counter: loads at the edge, decrements every cycle, holds at zero.
  always @(posedge clk) begin
    if (rst) cnt <= 4'd0;
    else if (bus.load_o) cnt <= bus.data_o;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign bus.zero_i = (cnt == 4'd0);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input string what,
                     input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] %s: observed %0h expected %0h", tag, idx, what, obs, exp);
    end
  endtask

  // One whole phase of n cycles: load only in cycle 0, fixed lamps/data, walk w,
  // pending flag p0 until an optional pulse at ped_at; optional flash change at flash_at.
  task automatic phase(input string tag, input logic [2:0] m, input logic [2:0] s,
                       input logic [3:0] d, input int n, input logic w, input logic p0,
                       input int ped_at, input int flash_at, input logic flash_val);
    for (int i = 0; i < n; i++) begin
      chk(tag, i, "main", {5'd0, bus.main_o}, {5'd0, m});
      chk(tag, i, "side", {5'd0, bus.side_o}, {5'd0, s});
      chk(tag, i, "data", {4'd0, bus.data_o}, {4'd0, d});
      chk(tag, i, "load", {7'd0, bus.load_o}, {7'd0, (i == 0)});
      chk(tag, i, "walk", {7'd0, bus.walk_o}, {7'd0, w});
      chk(tag, i, "pend", {7'd0, bus.ped_pend_o},
          {7'd0, p0 | (ped_at >= 0 && i > ped_at)});
      bus.ped_req_i = (i == ped_at);
      if (i == flash_at) bus.flash_i = flash_val;
      cyc();
    end
    bus.ped_req_i = 1'b0;
  endtask

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  initial begin
    rst = 1'b1;
    bus.ped_req_i = 1'b0;
    bus.flash_i = 1'b0;
    cyc();
    chk("rst", 0, "main", {5'd0, bus.main_o}, {5'd0, R});
    chk("rst", 0, "side", {5'd0, bus.side_o}, {5'd0, R});
    chk("rst", 0, "load", {7'd0, bus.load_o}, 8'd1);
    chk("rst", 0, "data", {4'd0, bus.data_o}, 8'd1);
    chk("rst", 0, "walk", {7'd0, bus.walk_o}, 8'd0);
    chk("rst", 0, "pend", {7'd0, bus.ped_pend_o}, 8'd0);
    cyc();
    rst = 1'b0;

    // Free run: 3 + 11 + 4 + 3 + 7 + 4 = 32-cycle period.
    phase("a_red2",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("a_maing", G, R, 4'd9, 11, 1'b0, 1'b0, -1, -1, 1'b0);
    phase("a_mainy", Y, R, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("a_red1",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("a_sideg", R, G, 4'd5, 7,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("a_sidey", R, Y, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);

    // Pedestrian pulse during main green, served by the next side green.
    phase("b_red2",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("b_maing", G, R, 4'd9, 11, 1'b0, 1'b0, 3,  -1, 1'b0);
    phase("b_mainy", Y, R, 4'd2, 4,  1'b0, 1'b1, -1, -1, 1'b0);
    phase("b_red1",  R, R, 4'd1, 3,  1'b0, 1'b1, -1, -1, 1'b0);
    phase("b_sideg", R, G, 4'd5, 7,  1'b1, 1'b0, -1, -1, 1'b0);
    phase("b_sidey", R, Y, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);

    // Following cycle without a request: no walk.
    phase("c_red2",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("c_maing", G, R, 4'd9, 11, 1'b0, 1'b0, -1, -1, 1'b0);
    phase("c_mainy", Y, R, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("c_red1",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("c_sideg", R, G, 4'd5, 7,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("c_sidey", R, Y, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);

    // Request in the very cycle that enters side green.
    phase("d_red2",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("d_maing", G, R, 4'd9, 11, 1'b0, 1'b0, -1, -1, 1'b0);
    phase("d_mainy", Y, R, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("d_red1",  R, R, 4'd1, 3,  1'b0, 1'b0, 2,  -1, 1'b0);
    phase("d_sideg", R, G, 4'd5, 7,  1'b1, 1'b0, -1, -1, 1'b0);
    phase("d_sidey", R, Y, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);

    // Flash raised mid main green; blink, pedestrian latch in flash, then flash dropped.
    phase("e_red2",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("e_maing", G, R, 4'd9, 11, 1'b0, 1'b0, -1, 5,  1'b1);
    phase("e_mainy", Y, R, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("e_red1",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("e_fl1",   Y, Y, 4'd3, 5,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("e_fl0",   O, O, 4'd3, 5,  1'b0, 1'b0, 1,  -1, 1'b0);
    phase("e_fl1b",  Y, Y, 4'd3, 5,  1'b0, 1'b1, -1, 2,  1'b0);
    phase("e_red2b", R, R, 4'd1, 3,  1'b0, 1'b1, -1, -1, 1'b0);
    phase("e_maing", G, R, 4'd9, 11, 1'b0, 1'b1, -1, -1, 1'b0);
    phase("e_mainy", Y, R, 4'd2, 4,  1'b0, 1'b1, -1, -1, 1'b0);
    phase("e_red1",  R, R, 4'd1, 3,  1'b0, 1'b1, -1, -1, 1'b0);

    // Reset mid side green with a new request pending.
    phase("f_sideg", R, G, 4'd5, 4,  1'b1, 1'b0, 2,  -1, 1'b0);
    chk("f_pre", 0, "pend", {7'd0, bus.ped_pend_o}, 8'd1);
    rst = 1'b1;
    cyc();
    chk("f_rst", 0, "main", {5'd0, bus.main_o}, {5'd0, R});
    chk("f_rst", 0, "side", {5'd0, bus.side_o}, {5'd0, R});
    chk("f_rst", 0, "walk", {7'd0, bus.walk_o}, 8'd0);
    chk("f_rst", 0, "pend", {7'd0, bus.ped_pend_o}, 8'd0);
    chk("f_rst", 0, "load", {7'd0, bus.load_o}, 8'd1);
    chk("f_rst", 0, "data", {4'd0, bus.data_o}, 8'd1);
    rst = 1'b0;
    phase("g_red2",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("g_maing", G, R, 4'd9, 11, 1'b0, 1'b0, -1, -1, 1'b0);
    phase("g_mainy", Y, R, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("g_red1",  R, R, 4'd1, 3,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("g_sideg", R, G, 4'd5, 7,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("g_sidey", R, Y, 4'd2, 4,  1'b0, 1'b0, -1, -1, 1'b0);
    phase("g_red2",  R, R, 4'd1, 1,  1'b0, 1'b0, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Phase controller for a two-road traffic light (main/side); the consumer of the down-counter's expiry flag and the producer of its load/data inputs.
- Each phase loads a duration into the shared down-counter (WIDTH bits) and advances when the counter reports zero.
- Adds a latched pedestrian request (walk light during side green) and a night flash mode.
- Sits between board inputs (buttons/switches) and the LED outputs; the counter is instantiated alongside it at top level.

Parameters:
- WIDTH, 4, width of data_o; must equal the counter's WIDTH.
- T_MAIN_G, 9, main-green duration in counter ticks (1..2^WIDTH-1).
- T_SIDE_G, 5, side-green duration (1..2^WIDTH-1).
- T_YEL, 2, yellow duration, both roads (1..2^WIDTH-1).
- T_RED, 1, all-red clearance duration (1..2^WIDTH-1).
- T_FLASH, 3, half-period of night-mode yellow blink (1..2^WIDTH-1).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- zero_i  in  1  counter expiry flag (counter zero_o).
- ped_req_i  in  1  pedestrian button, level or pulse, already synchronised.
- flash_i  in  1  night-mode request switch.
- load_o  out  1  counter load strobe (to counter load_i).
- data_o  out  WIDTH  duration for the current phase (to counter data_i).
- main_o  out  3  main-road lamps {red,yellow,green}.
- side_o  out  3  side-road lamps {red,yellow,green}.
- walk_o  out  1  pedestrian walk lamp.
- ped_pend_o  out  1  pedestrian request latched, not yet served.

Behaviour:
- States: MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2, FLASH.
- Normal cycle: RED2 -> MAIN_G -> MAIN_Y -> RED1 -> SIDE_G -> SIDE_Y -> RED2.
- Durations: MAIN_G=T_MAIN_G, SIDE_G=T_SIDE_G, *_Y=T_YEL, RED1/RED2=T_RED, FLASH=T_FLASH. data_o is combinational from the state.
- Entry flag entry_q:
  - Set on every state entry, including FLASH re-entry.
  - load_o = entry_q, high exactly one cycle.
  - zero_i is ignored while load_o=1, since the counter value is stale that cycle.
- Advance: the state advances on the edge ending the first cycle with load_o=0 and zero_i=1.
- Dwell: with a counter that loads at the edge and decrements every cycle, each state lasts D+2 cycles, where D is its duration.
- Lamps:
  - MAIN_G: main=001, side=100.
  - MAIN_Y: main=010, side=100.
  - RED1/RED2: both 100.
  - SIDE_G: main=100, side=001.
  - SIDE_Y: main=100, side=010.
  - FLASH: both = {0,blink_q,0}.
- Pedestrian request:
  - ped_pend_o is set by ped_req_i=1 in any cycle.
  - It is cleared on the edge entering SIDE_G if set at that edge; a request arriving in that same cycle is consumed.
  - walk_q is captured at SIDE_G entry (= pend) and held until SIDE_G exits. walk_o = walk_q & (state==SIDE_G); it is 0 elsewhere.
- Flash mode:
  - Entry: at expiry in RED1 or RED2 with flash_i=1, go to FLASH; blink_q<=1.
  - Each FLASH expiry with flash_i=1: stay in FLASH, toggle blink_q, re-load.
  - FLASH expiry with flash_i=0: go to RED2, blink_q<=0.
  - flash_i is sampled only at expiry; changes mid-phase never cut a phase short.
  - Pedestrian latching continues in FLASH; walk_o stays 0.
- Reset (any cycle, including mid-phase): state=RED2, entry_q=1, blink_q=0, walk_q=0, ped_pend=0.
  - Outputs while rst_i=1: main=side=100, walk_o=0, ped_pend_o=0, load_o=1, data_o=T_RED.
  - First cycle after release: load_o=1 (RED2 load).
- Outputs carry no X after the first reset edge. Illegal state encodings recover to RED2 with entry_q=1.

Test Plan:
- Reset, free run with default counter (WIDTH=4):
  - Post-release cycle 0 has load_o=1, data_o=1.
  - Dwell cycles: RED2 3, MAIN_G 11 (data_o=9), MAIN_Y 4, RED1 3, SIDE_G 7, SIDE_Y 4.
  - Period is 32 cycles; never green on both roads; load_o high exactly once per state.
- Pedestrian:
  - 1-cycle ped_req_i pulse during MAIN_G -> ped_pend_o=1 next cycle, held to SIDE_G entry.
  - walk_o=1 for all 7 SIDE_G cycles; ped_pend_o=0 from SIDE_G entry.
  - The following cycle with no request has walk_o=0 throughout.
- Request at boundary: ped_req_i=1 in the cycle entering SIDE_G -> served this SIDE_G (walk_o=1); ped_pend_o=0 afterwards.
- Flash mode:
  - flash_i=1 raised mid MAIN_G -> MAIN_G still lasts 11 cycles; FLASH is entered after RED1.
  - Both roads then alternate 010/000 every 5 cycles.
  - flash_i=0 -> finishes the current 5-cycle blink, then RED2 (3 cycles), then MAIN_G.
- Reset mid-operation: rst_i high 1 cycle during SIDE_G with ped_pend_o=1 -> next cycle main=side=100, walk_o=0, ped_pend_o=0, load_o=1, data_o=1; a full normal cycle follows.
- Stale-zero guard: counter at 0 when load_o=1 (entry from RED) -> no advance in the load cycle; the state still lasts D+2 cycles.
